jk_counter_ctrl: RTL
====================

# jk_counter_ctrl

Sequencer for a bank of JK flip-flops with synchronous clear. It computes the J/K excitation for each flip-flop every cycle, so the bank behaves as a run/stop-controlled, loadable, mod-MOD up/down counter. It sits between lab control inputs (buttons/switches) and the flip-flop datapath. It also exposes the excitation vectors, so excitation-table behaviour can be checked directly on the waveform.

## Interface
- WIDTH, 4, number of JK flip-flops / counter bits
- MOD, 10, counter modulus; legal range 2..2^WIDTH

- clk  in  1  clock, rising-edge active
- clr  in  1  reset, synchronous, active-high
- start  in  1  level, sampled each edge; IDLE -> RUN
- stop  in  1  level, sampled each edge; RUN -> IDLE
- en  in  1  count enable in RUN
- up  in  1  direction: 1 = up, 0 = down
- load  in  1  load request, any state
- load_val  in  WIDTH  value to load
- J  out  WIDTH  J excitation driven into the flip-flop bank
- K  out  WIDTH  K excitation driven into the flip-flop bank
- count  out  WIDTH  flip-flop bank Q outputs
- busy  out  1  1 when state is RUN
- tc  out  1  terminal count
- err  out  1  one-cycle pulse: illegal load value was rejected

## Operation
- FSM has two states:
  - IDLE: reset state; count holds.
  - RUN: counts when en = 1.
- Priority per edge, highest first: clr > load > stop > start > count.
- clr:
  - all flip-flops reach 0; state = IDLE; err = 0.
  - J = K = 0 while clr is high.
- load:
  - next = load_val if load_val < MOD; otherwise next = 0 and err = 1 on the following cycle.
  - State is unchanged.
- stop in RUN: state -> IDLE; count holds.
- start in IDLE: state -> RUN; count holds on that edge.
- Counting, in RUN with en = 1 and no load/stop:
  - up: next = (count == MOD-1) ? 0 : count+1
  - down: next = (count == 0) ? MOD-1 : count-1
- Next-state arithmetic is done in WIDTH bits. Wrap is explicit at MOD, never natural 2^WIDTH overflow (unless MOD = 2^WIDTH).
- Excitation per bit i, with don't-cares resolved to 0:
  - J[i] = ~count[i] & next[i]
  - K[i] = count[i] & ~next[i]
  - When holding (next == count), J = K = 0. No toggle encoding (J = K = 1) is ever produced.
- tc = busy & en & ((up & count == MOD-1) | (~up & count == 0)).
- start and stop in the same cycle: stop wins in RUN; start wins in IDLE, because stop has no effect there.

## Timing
- Single clock domain; all state changes on rising clk.
- J/K/tc are combinational from count, state and inputs, and valid before the next edge.
- Load latency: 1 edge. load_val appears on count after the sampling edge.
- Start latency: start sampled at edge k gives busy = 1 after k; the first increment is at edge k+1 if en = 1.
- Stop takes effect at the sampling edge; no further counting occurs.
- err is registered: high for exactly the one cycle after the rejecting edge.
- Reset values: count = 0, busy = 0, tc = 0, err = 0, J = 0, K = 0.
- clr mid-count clears at the next edge regardless of load, start or en.

## Structure
- Shared package jk_ctrl_pkg holds:
  - state encoding constants (IDLE = 0, RUN = 1)
  - default WIDTH and MOD
- Sub-module jk_ff: one JK flip-flop with synchronous active-high clr, Q/Qbar outputs, instantiated WIDTH times via generate.
- Top level contains the FSM register, the next-value logic, the J/K excitation logic, and the err register.

## Test plan
Bench configuration: WIDTH = 4, MOD = 10.

1. Reset: clr high for 2 edges with random inputs -> count = 0, busy = 0, tc = 0, err = 0, J = K = 0; after release with no start, count stays 0.
2. Up count: start, then en = 1, up = 1 for 12 edges.
   - count goes 0,1,…,9,0,1.
   - tc = 1 only while count = 9.
   - At count = 1, J = 0010 and K = 0001.
   - At count = 9, J = 0000 and K = 1001.
3. Down count: from 0 in RUN with up = 0 -> count 9,8,7; tc = 1 while count = 0; at count = 0, J = 1001 and K = 0000.
4. Load during RUN counting up:
   - load_val = 7 -> count = 7 next edge, then 8.
   - load_val = 12 -> count = 0, err = 1 for exactly one cycle.
5. Command conflicts:
   - start and stop together in RUN -> busy = 0, count holds.
   - clr asserted together with load = 1 at count = 5 -> count = 0, busy = 0.
   - en = 0 in RUN -> count holds, J = K = 0, tc = 0.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK counter controller.
// Contents: default counter width and modulus, FSM state encoding.
package jk_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_MOD   = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-high clear.
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous clear, forces q to 0
//   j, k - excitation inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q    - stored bit
//   qbar - complement of q
module jk_ff (
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Run/stop-controlled, loadable mod-MOD up/down counter built from a bank
// of JK flip-flops. The controller computes the next count value each cycle
// and converts it into per-bit J/K excitation for the bank.
// Ports:
//   clk, clr          - clock, synchronous active-high clear
//   start, stop       - level commands: IDLE->RUN, RUN->IDLE
//   en, up            - count enable (RUN only), direction (1 = up)
//   load, load_val    - load request and value (rejected if >= MOD)
//   J, K              - excitation driven into the flip-flop bank
//   count             - flip-flop bank Q outputs
//   busy              - high while in RUN
//   tc                - terminal count for the current direction
//   err               - one-cycle pulse after an illegal load was rejected
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | reset state; count holds unless loaded
// RUN   | count advances by one (mod MOD) when en = 1
module jk_counter_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = DEFAULT_MOD
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             err
);

  // One extra bit so MOD = 2^WIDTH still compares correctly against load_val.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_b;
  logic [WIDTH-1:0] next_val;
  logic             err_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == CNT_MAX);
  assign at_zero = (count == '0);

  // Priority: clr > load > stop > start > count.
  always_comb begin
    next_val  = count;
    state_nxt = state;
    err_nxt   = 1'b0;
    if (clr) begin
      next_val  = '0;
      state_nxt = IDLE;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        next_val = load_val;
      end else begin
        next_val = '0;
        err_nxt  = 1'b1;
      end
    end else if (state == RUN && stop) begin
      state_nxt = IDLE;
    end else if (state == IDLE && start) begin
      state_nxt = RUN;
    end else if (state == RUN && en) begin
      if (up) begin
        next_val = at_max ? '0 : count + WIDTH'(1);
      end else begin
        next_val = at_zero ? CNT_MAX : count - WIDTH'(1);
      end
    end
  end

  // Set only bits going 0->1, reset only bits going 1->0; never toggle.
  // While clr is high the bank is cleared through its own clr pin.
  always_comb begin
    J = '0;
    K = '0;
    if (!clr) begin
      J = count_b & next_val;
      K = count & ~next_val;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
    end
  end

  assign busy = (state == RUN);
  assign tc   = busy & en & ((up & at_max) | (~up & at_zero));

  for (genvar i = 0; i < WIDTH; i++) begin : g_ff
    jk_ff u_ff (
      .clk  (clk),
      .clr  (clr),
      .j    (J[i]),
      .k    (K[i]),
      .q    (count[i]),
      .qbar (count_b[i])
    );
  end

endmodule
